// File: rtl/axis_tap_ctrl.sv
// ---------------------------------------------------------------------------
// axis_tap_ctrl
//
// Capture controller and source selector in front of an AXI4-Stream tap.
// Watches PORTS passive stream taps. On command it picks one of them and
// forwards a programmed number of whole frames. Forwarding always starts and
// ends on a frame boundary. The tap path has no backpressure, so every
// forwarded beat appears as one cycle of m_tap_tvalid (with m_tap_tready
// mirroring it), one cycle after it was observed on the selected port.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   s_tap_*           : PORTS monitored streams, packed port-major
//                       (port i at [i*W +: W])
//   m_tap_*           : forwarded tap-style beat bundle (registered)
//   cfg_sel/cfg_count : port and frame count, sampled on cfg_start
//                       (cfg_count == 0 means unlimited)
//   cfg_start         : single-cycle start pulse, honoured only when idle
//   cfg_stop          : single-cycle stop pulse, finishes on a frame boundary
//   status_busy       : controller is not idle
//   status_done       : one-cycle pulse when a capture completes or stops
//   status_error      : sticky, start requested with an out-of-range select
//   status_sel        : select latched by the last accepted start
//   status_frames     : whole frames forwarded since start (saturating)
// ---------------------------------------------------------------------------
module axis_tap_ctrl #(
  parameter int PORTS       = 4,
  parameter int SEL_WIDTH   = (PORTS > 1) ? $clog2(PORTS) : 1,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8 > 0) ? DATA_WIDTH / 8 : 1,
  parameter int USER_WIDTH  = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic [PORTS*DATA_WIDTH-1:0]  s_tap_tdata,
  input  logic [PORTS*KEEP_WIDTH-1:0]  s_tap_tkeep,
  input  logic [PORTS-1:0]             s_tap_tvalid,
  input  logic [PORTS-1:0]             s_tap_tready,
  input  logic [PORTS-1:0]             s_tap_tlast,
  input  logic [PORTS*USER_WIDTH-1:0]  s_tap_tuser,

  output logic [DATA_WIDTH-1:0]        m_tap_tdata,
  output logic [KEEP_WIDTH-1:0]        m_tap_tkeep,
  output logic                         m_tap_tvalid,
  output logic                         m_tap_tready,
  output logic                         m_tap_tlast,
  output logic [USER_WIDTH-1:0]        m_tap_tuser,

  input  logic [SEL_WIDTH-1:0]         cfg_sel,
  input  logic [COUNT_WIDTH-1:0]       cfg_count,
  input  logic                         cfg_start,
  input  logic                         cfg_stop,

  output logic                         status_busy,
  output logic                         status_done,
  output logic                         status_error,
  output logic [SEL_WIDTH-1:0]         status_sel,
  output logic [COUNT_WIDTH-1:0]       status_frames
);

  // One extra bit so that PORTS itself is representable when comparing
  // against a select that may be wider than needed.
  localparam logic [SEL_WIDTH:0] PORTS_LIMIT = (SEL_WIDTH + 1)'(PORTS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t                  state_reg,  state_next;
  logic [SEL_WIDTH-1:0]    sel_reg,    sel_next;
  logic [COUNT_WIDTH-1:0]  count_reg,  count_next;
  logic [COUNT_WIDTH-1:0]  frames_reg, frames_next;
  logic                    error_reg,  error_next;
  logic                    done_reg,   done_next;

  logic [PORTS-1:0]        xfer;
  logic [PORTS-1:0]        in_frame_reg, in_frame_next;

  logic [DATA_WIDTH-1:0]   tdata_reg;
  logic [KEEP_WIDTH-1:0]   tkeep_reg;
  logic                    tvalid_reg;
  logic                    tlast_reg;
  logic [USER_WIDTH-1:0]   tuser_reg;

  // Selected-port view of the monitored streams
  logic [DATA_WIDTH-1:0]   sel_tdata;
  logic [KEEP_WIDTH-1:0]   sel_tkeep;
  logic [USER_WIDTH-1:0]   sel_tuser;
  logic                    sel_tlast;
  logic                    sel_xfer;
  logic                    sel_in_frame;

  logic                    fwd;
  logic                    start_invalid;
  logic [COUNT_WIDTH-1:0]  frames_inc;
  logic                    count_hit;

  // -------------------------------------------------------------------------
  // Per-port frame tracking. Runs on every port regardless of controller
  // state so that a capture armed mid-frame knows to wait for the boundary.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
      assign xfer[gi] = s_tap_tvalid[gi] & s_tap_tready[gi];

      always_comb begin
        in_frame_next[gi] = in_frame_reg[gi];
        if (xfer[gi]) begin
          in_frame_next[gi] = ~s_tap_tlast[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      in_frame_reg <= '0;
    end else begin
      in_frame_reg <= in_frame_next;
    end
  end

  // -------------------------------------------------------------------------
  // Port selection mux. Compare-and-select rather than indexing so that a
  // select wider than strictly needed never reaches past the last port.
  // -------------------------------------------------------------------------
  always_comb begin
    sel_tdata    = '0;
    sel_tkeep    = '0;
    sel_tuser    = '0;
    sel_tlast    = 1'b0;
    sel_xfer     = 1'b0;
    sel_in_frame = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (sel_reg == SEL_WIDTH'(i)) begin
        sel_tdata    = s_tap_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_tkeep    = s_tap_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_tuser    = s_tap_tuser[i*USER_WIDTH +: USER_WIDTH];
        sel_tlast    = s_tap_tlast[i];
        sel_xfer     = xfer[i];
        sel_in_frame = in_frame_reg[i];
      end
    end
  end

  // A beat is forwarded once the capture is frame-aligned: in SYNC only a
  // transfer that begins a new frame qualifies.
  assign fwd = sel_xfer &&
               ((state_reg == CAPTURE) || (state_reg == DRAIN) ||
                ((state_reg == SYNC) && !sel_in_frame));

  assign start_invalid = ({1'b0, cfg_sel} >= PORTS_LIMIT);

  assign frames_inc = (frames_reg == '1) ? frames_reg
                                         : frames_reg + COUNT_WIDTH'(1);

  // Compared against the post-increment value: the frame that reaches the
  // programmed count is the last one forwarded.
  assign count_hit = (count_reg != '0) && (frames_inc == count_reg);

  // -------------------------------------------------------------------------
  // Controller FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      sel_reg    <= '0;
      count_reg  <= '0;
      frames_reg <= '0;
      error_reg  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sel_reg    <= sel_next;
      count_reg  <= count_next;
      frames_reg <= frames_next;
      error_reg  <= error_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    count_next  = count_reg;
    frames_next = frames_reg;
    error_next  = error_reg;
    done_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (cfg_start) begin
          if (start_invalid) begin
            error_next = 1'b1;
          end else begin
            sel_next    = cfg_sel;
            count_next  = cfg_count;
            frames_next = '0;
            error_next  = 1'b0;
            state_next  = SYNC;
          end
        end
      end

      // SYNC and CAPTURE share handling once a beat is actually forwarded;
      // they differ only in which beats qualify (see fwd) and in how a stop
      // without a forwarded beat is treated.
      SYNC, CAPTURE: begin
        if (fwd) begin
          if (sel_tlast) begin
            frames_next = frames_inc;
            if (cfg_stop || count_hit) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end else begin
              state_next = CAPTURE;
            end
          end else if (cfg_stop) begin
            // The forwarded frame is now open; finish it before stopping.
            state_next = DRAIN;
          end else begin
            state_next = CAPTURE;
          end
        end else if (cfg_stop) begin
          // In CAPTURE the selected port's frame tracker doubles as "a
          // forwarded frame is open", since capture began on a boundary.
          if ((state_reg == SYNC) || !sel_in_frame) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (fwd && sel_tlast) begin
          frames_next = frames_inc;
          state_next  = IDLE;
          done_next   = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Forwarded beat register. Payload fields hold between beats.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tvalid_reg <= 1'b0;
      tlast_reg  <= 1'b0;
      tdata_reg  <= '0;
      tkeep_reg  <= '0;
      tuser_reg  <= '0;
    end else begin
      tvalid_reg <= fwd;
      if (fwd) begin
        tlast_reg <= sel_tlast;
        tdata_reg <= sel_tdata;
        tkeep_reg <= sel_tkeep;
        tuser_reg <= sel_tuser;
      end
    end
  end

  assign m_tap_tdata   = tdata_reg;
  assign m_tap_tkeep   = tkeep_reg;
  assign m_tap_tvalid  = tvalid_reg;
  assign m_tap_tready  = tvalid_reg;
  assign m_tap_tlast   = tlast_reg;
  assign m_tap_tuser   = tuser_reg;

  assign status_busy   = (state_reg != IDLE);
  assign status_done   = done_reg;
  assign status_error  = error_reg;
  assign status_sel    = sel_reg;
  assign status_frames = frames_reg;

endmodule

// File: doc/axis_tap_ctrl.md
Name: axis_tap_ctrl

Overview:
- Capture controller and source selector placed in front of an AXI4-Stream tap.
- Watches up to PORTS passive stream taps and selects one under configuration control.
- Starts forwarding only on a frame boundary, forwards a programmed number of whole frames, then stops cleanly on a frame boundary.
- Output is a tap-style bundle (tvalid and tready both asserted on each forwarded transfer) that feeds the tap/truncation stage.

Parameters:
- PORTS, 4, number of monitored streams (1..16)
- SEL_WIDTH, $clog2(PORTS) (min 1), width of port select
- DATA_WIDTH, 8, tdata width per port
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width per port
- USER_WIDTH, 1, tuser width per port
- COUNT_WIDTH, 16, frame counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_tap_tdata  in  PORTS*DATA_WIDTH  monitored tdata, port i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_tap_tkeep  in  PORTS*KEEP_WIDTH  monitored tkeep
- s_tap_tvalid  in  PORTS  monitored tvalid
- s_tap_tready  in  PORTS  monitored tready
- s_tap_tlast  in  PORTS  monitored tlast
- s_tap_tuser  in  PORTS*USER_WIDTH  monitored tuser
- m_tap_tdata  out  DATA_WIDTH  forwarded data
- m_tap_tkeep  out  KEEP_WIDTH  forwarded keep
- m_tap_tvalid  out  1  forwarded transfer strobe
- m_tap_tready  out  1  equals m_tap_tvalid
- m_tap_tlast  out  1  forwarded last
- m_tap_tuser  out  USER_WIDTH  forwarded user
- cfg_sel  in  SEL_WIDTH  port to capture, sampled on cfg_start
- cfg_count  in  COUNT_WIDTH  frames to capture, 0 = unlimited, sampled on cfg_start
- cfg_start  in  1  single-cycle start pulse
- cfg_stop  in  1  single-cycle stop pulse
- status_busy  out  1  high in any state except IDLE
- status_done  out  1  one-cycle pulse on completion or stop
- status_error  out  1  sticky; set when cfg_start has cfg_sel>=PORTS; cleared by the next valid start
- status_sel  out  SEL_WIDTH  latched select
- status_frames  out  COUNT_WIDTH  frames forwarded since start, saturating

Behaviour:
- Transfer definition: transfer on port i = s_tap_tvalid[i] && s_tap_tready[i].
- Frame tracking: in_frame_reg[i] tracks every port at all times, independent of state.
  - Set on a transfer with !tlast; cleared on a transfer with tlast.
- Forward condition, per cycle: transfer on sel_reg and (state==CAPTURE, or state==DRAIN, or (state==SYNC && !in_frame_reg[sel_reg])).
- Output latency: one cycle. All m_tap_* are registered; m_tap_tvalid is high for exactly one cycle per forwarded beat.
  - Data fields update only on a forwarded beat and hold otherwise.
- States:
  - IDLE: nothing forwarded.
    - cfg_start with cfg_sel<PORTS: latch sel/count, clear frames, clear error, go to SYNC.
    - cfg_start with cfg_sel>=PORTS: set error, stay IDLE.
  - SYNC: on the first forwarded beat, go to CAPTURE, or apply end-of-frame handling if that beat has tlast (single-beat frame).
    - cfg_stop goes to IDLE with a done pulse.
  - CAPTURE: forward beats.
    - On a forwarded tlast: frames += 1 (saturating).
    - If cfg_count!=0 and the new frames==cfg_count: go to IDLE, pulse done. Otherwise go to SYNC-equivalent open state (remain CAPTURE).
    - cfg_stop with no forwarded frame open: go to IDLE, pulse done.
    - cfg_stop with a frame open: go to DRAIN.
    - cfg_stop coincident with a forwarded tlast: the beat is forwarded and counted, then go to IDLE.
  - DRAIN: forward until tlast (counted), then go to IDLE and pulse done. cfg_stop is ignored.
- Restrictions:
  - cfg_start outside IDLE is ignored.
  - cfg_sel/cfg_count changes outside cfg_start have no effect.
- Reset: synchronous; applies mid-operation with immediate effect, no partial frame completion.
  - State goes to IDLE.
  - in_frame_reg, m_tap_tvalid, m_tap_tready, m_tap_tlast, status_busy, status_done, status_error, status_frames all go to 0.
  - status_sel, m_tap_tdata, m_tap_tkeep, m_tap_tuser go to 0.
- No backpressure: the tap path cannot stall. Truncation on overflow is the downstream tap's responsibility.

Test Plan:
- Start sel=2 count=2 while port 2 idle; port 2 sends frames of 3, 2 and 1 beats -> first two frames appear on m_tap one cycle delayed, status_frames=2, done pulse after the 2nd tlast, third frame not forwarded, busy=0.
- Start sel=1 count=0 mid-frame on port 1 (beat 2 of 4) -> remaining beats suppressed; the next frame is forwarded from its first beat; status_frames increments per frame.
- cfg_stop on beat 2 of a 5-beat frame in CAPTURE -> beats 3-5 forwarded (DRAIN), frames incremented, done pulse, then IDLE; the following frame is not forwarded.
- Start with cfg_sel=PORTS -> status_error=1, busy=0. Then a valid start -> error cleared, busy=1.
- Traffic on unselected ports 0 and 3 while capturing port 1, including tvalid without tready -> only port 1 transfers forwarded; stalled beats never produce m_tap_tvalid.
- rst asserted during beat 2 of a capture -> next cycle all outputs 0 and state IDLE; a later start with port 1 idle captures a full frame cleanly.
